mips_mc_control: RTL

Multicycle control sequencer for the MIPS multicycle datapath. It holds the main instruction FSM, decodes the 6-bit opcode and drives every enable and mux select for the PC, instruction register, memory, ALU and register file. The register file write enable `rf_we` and the `regdst`/`memtoreg` selects come from here. It also handshakes with a variable-latency unified memory and counts retired instructions.

---
 rtl/mips_mc_control.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/mips_mc_control.sv
// Multicycle MIPS control sequencer: main instruction FSM, opcode decode, datapath
// enables/selects, memory handshake and retired-instruction counter.
module mips_mc_control (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic        alu_zero,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        iord,
  output logic        ir_we,
  output logic        pc_we,
  output logic [1:0]  pcsrc,
  output logic        rf_we,
  output logic        regdst,
  output logic        memtoreg,
  output logic        alusrca,
  output logic [1:0]  alusrcb,
  output logic [1:0]  aluop,
  output logic        illegal,
  output logic [31:0] instr_count
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMRD,
    S_MEMWB,
    S_MEMWR,
    S_EXEC,
    S_ALUWB,
    S_BRANCH,
    S_ADDIEXEC,
    S_ADDIWB,
    S_JUMP,
    S_ERROR
  } state_t;

  state_t      state_reg;
  logic [31:0] instr_count_reg;
  logic        retire;

  // funct is decoded by the external ALU control, not here.
  logic unused_funct;
  assign unused_funct = ^funct;

  logic       mem_req_c;
  logic       mem_we_c;
  logic       ir_we_c;
  logic       pc_we_c;
  logic       rf_we_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= S_FETCH;
      instr_count_reg <= '0;
    end else begin
      if (retire)
        instr_count_reg <= instr_count_reg + 32'd1;
      case (state_reg)
        S_FETCH:    if (mem_ready) state_reg <= S_DECODE;
        S_DECODE: begin
          case (opcode)
            OP_LW, OP_SW: state_reg <= S_MEMADR;
            OP_RTYPE:     state_reg <= S_EXEC;
            OP_BEQ:       state_reg <= S_BRANCH;
            OP_ADDI:      state_reg <= S_ADDIEXEC;
            OP_J:         state_reg <= S_JUMP;
            default:      state_reg <= S_ERROR;
          endcase
        end
        S_MEMADR:   state_reg <= (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
        S_MEMRD:    if (mem_ready) state_reg <= S_MEMWB;
        S_MEMWB:    state_reg <= S_FETCH;
        S_MEMWR:    if (mem_ready) state_reg <= S_FETCH;
        S_EXEC:     state_reg <= S_ALUWB;
        S_ALUWB:    state_reg <= S_FETCH;
        S_BRANCH:   state_reg <= S_FETCH;
        S_ADDIEXEC: state_reg <= S_ADDIWB;
        S_ADDIWB:   state_reg <= S_FETCH;
        S_JUMP:     state_reg <= S_FETCH;
        S_ERROR:    state_reg <= S_ERROR;
        default:    state_reg <= S_ERROR;
      endcase
    end
  end

  // Retirement happens on the edge that ends an instruction's final state.
  always_comb begin
    retire = 1'b0;
    case (state_reg)
      S_MEMWB, S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP: retire = 1'b1;
      S_MEMWR: retire = mem_ready;
      default: retire = 1'b0;
    endcase
  end

  always_comb begin
    mem_req_c = 1'b0;
    mem_we_c  = 1'b0;
    ir_we_c   = 1'b0;
    pc_we_c   = 1'b0;
    rf_we_c   = 1'b0;
    iord      = 1'b0;
    pcsrc     = 2'b00;
    regdst    = 1'b0;
    memtoreg  = 1'b0;
    alusrca   = 1'b0;
    alusrcb   = 2'b00;
    aluop     = 2'b00;
    illegal   = 1'b0;
    case (state_reg)
      S_FETCH: begin
        mem_req_c = 1'b1;
        alusrcb   = 2'b01;
        ir_we_c   = mem_ready;
        pc_we_c   = mem_ready;
      end
      S_DECODE: alusrcb = 2'b11;
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      S_MEMRD: begin
        mem_req_c = 1'b1;
        iord      = 1'b1;
      end
      S_MEMWB: begin
        rf_we_c  = 1'b1;
        memtoreg = 1'b1;
      end
      S_MEMWR: begin
        mem_req_c = 1'b1;
        mem_we_c  = 1'b1;
        iord      = 1'b1;
      end
      S_EXEC: begin
        alusrca = 1'b1;
        aluop   = 2'b10;
      end
      S_ALUWB: begin
        rf_we_c = 1'b1;
        regdst  = 1'b1;
      end
      S_BRANCH: begin
        alusrca = 1'b1;
        aluop   = 2'b01;
        pcsrc   = 2'b01;
        pc_we_c = alu_zero;
      end
      S_ADDIEXEC: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      S_ADDIWB: rf_we_c = 1'b1;
      S_JUMP: begin
        pc_we_c = 1'b1;
        pcsrc   = 2'b10;
      end
      S_ERROR: illegal = 1'b1;
      default: illegal = 1'b1;
    endcase
  end

  // Reset kills every access and write immediately, even before the state flop settles.
  assign mem_req     = mem_req_c & ~rst;
  assign mem_we      = mem_we_c  & ~rst;
  assign ir_we       = ir_we_c   & ~rst;
  assign pc_we       = pc_we_c   & ~rst;
  assign rf_we       = rf_we_c   & ~rst;
  assign instr_count = instr_count_reg;

endmodule
